// File: rtl/cpu_types_pkg.sv
//============================================================================
// cpu_types_pkg : shared RAM-handshake and arbiter state types -- rev 1.0
//============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    DBST = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_streak.sv
//============================================================================
// mem_arb_streak : saturating count of data grants won over a waiting I$ -- rev 1.0
//============================================================================
`default_nettype none

module mem_arb_streak #(
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = $clog2(MAX_D_STREAK + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic             sat_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != C_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sat_o = (cnt_q == C_MAX);
  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//============================================================================
// mem_arbiter : I$/D$ single-port RAM arbiter, D$ priority, burst lock -- rev 1.0
//============================================================================
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_t    state_q, state_d;
  logic          streak_inc, streak_clr, streak_sat;
  logic [SW-1:0] streak_cnt;
  logic          dreq, access, starve;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == ACCESS);
  assign starve = iREN & streak_sat;

  mem_arb_streak #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .CNT_W        (SW)
  ) u_streak (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (streak_inc),
    .clr_i (streak_clr),
    .sat_o (streak_sat),
    .cnt_o (streak_cnt)
  );

  always_comb begin
    state_d    = state_q;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq && !starve) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (access) begin
          iwait      = 1'b0;
          streak_clr = 1'b1;
          state_d    = IDLE;
        end
      end
      DGNT, DBST: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq) begin
          state_d = IDLE;
        end else if (access) begin
          dwait = 1'b0;
          // Only the first word of a block counts toward the streak; the
          // even-word address locks the odd word in right behind it.
          if (state_q == DGNT) begin
            streak_inc = iREN;
            streak_clr = ~iREN;
            state_d    = daddr[2] ? IDLE : DBST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//============================================================================
// tb_mem_arbiter : directed vector table plus starvation/reset sequences -- rev 1.0
//============================================================================
`default_nettype none

module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, ir, dr, dw;
    logic [31:0] ia, da, ds;
    ramstate_t   rs;
    logic [31:0] rl;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_st;
    logic        e_iw, e_dw;
    arb_state_t  e_state;
    logic [2:0]  e_streak;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic rst, logic ir, logic dr, logic dw,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                              ramstate_t rs, logic [31:0] rl,
                              logic ren, logic wen, logic [31:0] addr, logic [31:0] st,
                              logic iw, logic dwt, arb_state_t s, logic [2:0] k);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
    v.e_ren = ren; v.e_wen = wen; v.e_addr = addr; v.e_st = st;
    v.e_iw = iw; v.e_dw = dwt; v.e_state = s; v.e_streak = k;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] st,
                           input logic iw, input logic dwt);
    @(negedge CLK);
    chk({tag, " bus"}, {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait},
        {ren, wen, addr, st, iw, dwt});
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;

    // reset / idle
    vecs[0]  = mk(1,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);
    vecs[1]  = mk(0,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);
    // lone instruction read, two BUSY cycles then ACCESS
    vecs[2]  = mk(0,1,0,0, 32'h40,0,0, FREE,0,        0,0,0,0, 1,1, IDLE,0);
    vecs[3]  = mk(0,1,0,0, 32'h40,0,0, BUSY,0,        1,0,32'h40,0, 1,1, IGNT,0);
    vecs[4]  = mk(0,1,0,0, 32'h40,0,0, BUSY,0,        1,0,32'h40,0, 1,1, IGNT,0);
    vecs[5]  = mk(0,1,0,0, 32'h40,0,0, ACCESS,32'hDEADBEEF, 1,0,32'h40,0, 0,1, IGNT,0);
    vecs[6]  = mk(0,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);
    // simultaneous request: data first, instruction after
    vecs[7]  = mk(0,1,1,0, 32'h80,32'h24,0, FREE,0,   0,0,0,0, 1,1, IDLE,0);
    vecs[8]  = mk(0,1,1,0, 32'h80,32'h24,0, ACCESS,32'h11112222, 1,0,32'h24,0, 1,0, DGNT,0);
    vecs[9]  = mk(0,1,0,0, 32'h80,0,0, FREE,0,        0,0,0,0, 1,1, IDLE,1);
    vecs[10] = mk(0,1,0,0, 32'h80,0,0, ACCESS,32'h33334444, 1,0,32'h80,0, 0,1, IGNT,1);
    vecs[11] = mk(0,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);
    // burst write 0x100/0x104 with iREN held
    vecs[12] = mk(0,1,0,1, 32'h80,32'h100,32'hA5A5, FREE,0,   0,0,0,0, 1,1, IDLE,0);
    vecs[13] = mk(0,1,0,1, 32'h80,32'h100,32'hA5A5, BUSY,0,   0,1,32'h100,32'hA5A5, 1,1, DGNT,0);
    vecs[14] = mk(0,1,0,1, 32'h80,32'h100,32'hA5A5, ACCESS,0, 0,1,32'h100,32'hA5A5, 1,0, DGNT,0);
    vecs[15] = mk(0,1,0,1, 32'h80,32'h104,32'h5A5A, ACCESS,0, 0,1,32'h104,32'h5A5A, 1,0, DBST,1);
    vecs[16] = mk(0,1,0,0, 32'h80,0,0, FREE,0,        0,0,0,0, 1,1, IDLE,1);
    vecs[17] = mk(0,1,0,0, 32'h80,0,0, ACCESS,32'h0BADF00D, 1,0,32'h80,0, 0,1, IGNT,1);
    vecs[18] = mk(0,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);
    // request dropped in DBST
    vecs[19] = mk(0,0,1,0, 0,32'h200,0, FREE,0,       0,0,0,0, 1,1, IDLE,0);
    vecs[20] = mk(0,0,1,0, 0,32'h200,0, ACCESS,32'h12345678, 1,0,32'h200,0, 1,0, DGNT,0);
    vecs[21] = mk(0,0,0,0, 0,32'h204,0, ACCESS,0,     0,0,32'h204,0, 1,1, DBST,0);
    vecs[22] = mk(0,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);
    // ERROR holds like BUSY
    vecs[23] = mk(0,0,1,0, 0,32'h30C,0, FREE,0,       0,0,0,0, 1,1, IDLE,0);
    vecs[24] = mk(0,0,1,0, 0,32'h30C,0, ERROR,0,      1,0,32'h30C,0, 1,1, DGNT,0);
    vecs[25] = mk(0,0,1,0, 0,32'h30C,0, ACCESS,32'hCAFEF00D, 1,0,32'h30C,0, 1,0, DGNT,0);
    vecs[26] = mk(0,0,0,0, 0,0,0, FREE,0,             0,0,0,0, 1,1, IDLE,0);

    step();

    for (int i = 0; i < 27; i++) begin
      RST = vecs[i].rst; iREN = vecs[i].ir; dREN = vecs[i].dr; dWEN = vecs[i].dw;
      iaddr = vecs[i].ia; daddr = vecs[i].da; dstore = vecs[i].ds;
      ramstate = vecs[i].rs; ramload = vecs[i].rl;
      @(negedge CLK);
      chk($sformatf("vec%0d bus", i),
          {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait},
          {vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_st,
           vecs[i].e_iw, vecs[i].e_dw});
      chk($sformatf("vec%0d state", i), 64'(dut.state_q), 64'(vecs[i].e_state));
      chk($sformatf("vec%0d streak", i), 64'(dut.streak_cnt), 64'(vecs[i].e_streak));
      if (!vecs[i].e_iw) chk($sformatf("vec%0d iload", i), 64'(iload), 64'(vecs[i].rl));
      if (!vecs[i].e_dw) chk($sformatf("vec%0d dload", i), 64'(dload), 64'(vecs[i].rl));
      step();
    end

    // starvation: four data grants win, the fifth request loses to IGNT
    iREN = 1; iaddr = 32'h500; dREN = 1; dWEN = 0; daddr = 32'h14; dstore = 0;
    ramstate = ACCESS; ramload = 32'h5555AAAA;
    for (int k = 0; k < 4; k++) begin
      check_bus($sformatf("starve idle%0d", k), 0, 0, 0, 0, 1, 1);
      chk($sformatf("starve streak%0d", k), 64'(dut.streak_cnt), 64'(k));
      step();
      check_bus($sformatf("starve dgnt%0d", k), 1, 0, 32'h14, 0, 1, 0);
      step();
    end
    @(negedge CLK);
    chk("starve sat streak", 64'(dut.streak_cnt), 64'd4);
    step();
    check_bus("starve ignt", 1, 0, 32'h500, 0, 0, 1);
    chk("starve ignt state", 64'(dut.state_q), 64'(IGNT));
    step();
    @(negedge CLK);
    chk("starve cleared", 64'(dut.streak_cnt), 64'd0);
    iREN = 0; dREN = 0; ramstate = FREE;
    step();

    // reset during a BUSY data grant
    iREN = 1; dREN = 1; daddr = 32'h44; ramstate = ACCESS;
    step();
    step();
    ramstate = BUSY;
    step();
    check_bus("rst pre", 1, 0, 32'h44, 0, 1, 1);
    chk("rst pre streak", 64'(dut.streak_cnt), 64'd1);
    RST = 1;
    step();
    check_bus("rst abort", 0, 0, 0, 0, 1, 1);
    chk("rst state", 64'(dut.state_q), 64'(IDLE));
    chk("rst streak", 64'(dut.streak_cnt), 64'd0);
    RST = 0; iREN = 0; dREN = 0; ramstate = FREE;
    step();
    check_bus("rst after", 0, 0, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-ported RAM interface between the instruction cache and the data cache. It sits between both caches and the RAM model. Data-cache requests have priority, and the two word accesses of one data-cache block are locked together as a burst. A streak counter bounds instruction-cache starvation.

## Interface
- MAX_D_STREAK, default 4: consecutive data grants allowed while an instruction request is pending.
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  instruction wait; 0 for exactly the cycle iload is valid.
- iload  out  32  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins if asserted together with dREN.
- daddr  in  32  data word address.
- dstore  in  32  data write value.
- dwait  out  1  data wait; 0 for exactly the cycle the access completes.
- dload  out  32  data read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states:
  - IDLE: no grant.
  - IGNT: instruction cache owns the RAM.
  - DGNT: data cache owns the RAM, first word.
  - DBST: data cache owns the RAM, locked second word.
- IDLE transitions:
  - (dREN|dWEN) and not starving: go to DGNT.
  - Otherwise, iREN: go to IGNT.
  - Starving means iREN && streak == MAX_D_STREAK. When starving, go to IGNT even if a data request is pending.
- IGNT:
  - Drive ramREN=1, ramaddr=iaddr.
  - On ramstate==ACCESS: iwait=0, go to IDLE, clear the streak counter.
- DGNT:
  - Drive ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - On ACCESS: dwait=0.
  - If daddr[2]==0, go to DBST. Otherwise go to IDLE.
  - Increment the streak counter if iREN is high; otherwise clear it.
- DBST:
  - Drives the same outputs as DGNT.
  - On ACCESS: dwait=0, go to IDLE.
  - If dREN and dWEN are both 0 in DBST, go to IDLE immediately with no RAM strobe.
  - DBST does not increment the streak counter. One burst counts as one grant.
- Streak counter:
  - Width is $clog2(MAX_D_STREAK+1).
  - Saturates at MAX_D_STREAK; no wrap.
- While ramstate is BUSY or FREE, the owner's wait stays 1 and the strobes stay asserted.
- ramstate ERROR is treated as BUSY: hold and retry. No timeout.
- The non-granted master always sees its wait = 1.
- iload and dload are both combinational copies of ramload. Each is valid only when the matching wait is 0.
- A request dropped while granted (IGNT with iREN=0, DGNT with dREN=dWEN=0) causes return to IDLE next cycle without completion.

## Timing
- Arbitration latency: request sampled in IDLE at edge N. Strobe is asserted in the cycle after edge N.
- Minimum access latency is 2 cycles: grant cycle plus the ACCESS cycle.
- A burst (DGNT, then DBST) has no IDLE cycle between the words. The instruction cache cannot interleave.
- After completion the FSM spends one cycle in IDLE before the next grant.
- Strobes, ramaddr and ramstore are combinational from the state register and the granted master's inputs.
- Reset values, while RST=1 and in the first cycle after it:
  - state IDLE, streak 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1.
- RST asserted mid-access aborts at the next edge, with no completion pulse.

## Structure
- cpu_types_pkg holds ramstate_t and the new arb_state_t enum (IDLE, IGNT, DGNT, DBST). The arbiter imports both.
- One sub-module, mem_arb_streak: a saturating counter with inc, clr and sat ports, parameterised by MAX_D_STREAK.
- The FSM and output muxing live in mem_arbiter.

## Test plan
- Lone instruction read: iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> iwait=0 for one cycle with iload=0xDEADBEEF. Total 4 cycles from request; dwait stays 1.
- Simultaneous request: iREN and dREN in the same cycle, streak=0 -> DGNT first; IGNT only after the data access completes.
- Burst lock: dWEN with daddr=0x100 then 0x104, iREN held high -> two consecutive RAM writes with no IGNT between; streak=1 afterwards.
- Starvation: MAX_D_STREAK=4, iREN held, five back-to-back single-word data reads at daddr[2]=1 -> the fifth request loses to IGNT; streak clears to 0.
- Request drop: dREN deasserted in DBST -> IDLE next cycle, ramREN=0, dwait stays 1.
- Reset mid-access: RST=1 during DGNT with ramstate=BUSY -> next cycle ramREN=ramWEN=0, dwait=1, state IDLE, streak 0.
